// File: rtl/br_arb_rr_burst.sv
// br_arb_rr_burst: round-robin arbiter with burst locking.
//
// Shares one downstream beat channel among NumRequesters requesters. A winner keeps
// the grant until its packet ends (request_last) or MaxBurstLength beats have moved,
// whichever comes first. Priority then rotates round-robin from the last owner.
//
// Optional feature macro: BR_ARB_RR_BURST_DROP_RELEASE_EN
//   defined   : an owner that drops request while locked releases the tenure at once
//               (grant=0 for that cycle, drop_error pulses).
//   undefined : drop_error tied low; a dropped owner request is an assertion failure.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   request      per-requester request
//   request_last per-requester end-of-packet marker for the current beat
//   ready        downstream accepts the granted beat this cycle
//   grant        onehot0 grant (combinational)
//   locked       burst tenure in progress (registered)
//   beat_count   beats transferred in the current tenure (registered)
//   drop_error   owner dropped its request mid-burst
module br_arb_rr_burst #(
    parameter int unsigned NumRequesters = 2,
    parameter int unsigned MaxBurstLength = 4,
    localparam int unsigned BeatCountWidth = $clog2(MaxBurstLength + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NumRequesters-1:0]  request,
    input  logic [NumRequesters-1:0]  request_last,
    input  logic                      ready,
    output logic [NumRequesters-1:0]  grant,
    output logic                      locked,
    output logic [BeatCountWidth-1:0] beat_count,
    output logic                      drop_error
);

    logic [NumRequesters-1:0]  last_grant_q, last_grant_d;
    logic [NumRequesters-1:0]  owner_q, owner_d;
    logic                      locked_q, locked_d;
    logic [BeatCountWidth-1:0] beat_count_q, beat_count_d;

    logic [NumRequesters-1:0]  higher_mask;
    logic [NumRequesters-1:0]  req_above;
    logic [NumRequesters-1:0]  rr_pick;
    logic                      owner_drop;
    logic                      xfer;
    logic                      tenure_end;

    // Bits strictly above the pointer position; these get first pick.
    always_comb begin : p_mask
        logic seen;
        seen = 1'b0;
        higher_mask = '0;
        for (int i = 0; i < NumRequesters; i++) begin
            higher_mask[i] = seen;
            seen = seen | last_grant_q[i];
        end
    end

    assign req_above = request & higher_mask;

    // Lowest set bit above the pointer, otherwise wrap to the lowest set bit overall.
    always_comb begin
        if (|req_above) begin
            rr_pick = req_above & (~req_above + NumRequesters'(1));
        end else begin
            rr_pick = request & (~request + NumRequesters'(1));
        end
    end

`ifdef BR_ARB_RR_BURST_DROP_RELEASE_EN
    assign owner_drop = locked_q & ~|(request & owner_q);
`else
    assign owner_drop = 1'b0;
`endif

    always_comb begin
        if (!locked_q) begin
            grant = rr_pick;
        end else if (owner_drop) begin
            grant = '0;
        end else begin
            grant = owner_q;
        end
    end

    assign xfer       = ready & |(grant & request);
    assign tenure_end = |(request_last & grant)
                      | ((32'(beat_count_q) + 32'd1) == MaxBurstLength);

    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        locked_d     = locked_q;
        beat_count_d = beat_count_q;
        if (owner_drop) begin
            last_grant_d = owner_q;
            locked_d     = 1'b0;
            beat_count_d = '0;
        end else if (xfer) begin
            last_grant_d = grant;
            owner_d      = grant;
            if (tenure_end) begin
                locked_d     = 1'b0;
                beat_count_d = '0;
            end else begin
                locked_d     = 1'b1;
                beat_count_d = beat_count_q + BeatCountWidth'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Pointer at the top requester so requester 0 wins first.
            last_grant_q <= {1'b1, {(NumRequesters - 1){1'b0}}};
            owner_q      <= '0;
            locked_q     <= 1'b0;
            beat_count_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            locked_q     <= locked_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign locked     = locked_q;
    assign beat_count = beat_count_q;
    assign drop_error = owner_drop;

    assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    assert property (@(posedge clk) disable iff (rst) $onehot(last_grant_q));
    assert property (@(posedge clk) disable iff (rst) 32'(beat_count_q) < MaxBurstLength);

    // A request may only be withdrawn once its beat has transferred.
    for (genvar i = 0; i < NumRequesters; i++) begin : g_req_hold
        assert property (@(posedge clk) disable iff (rst)
            request[i] && !(xfer && grant[i]) |=> request[i]);
    end

`ifndef BR_ARB_RR_BURST_DROP_RELEASE_EN
    assert property (@(posedge clk) disable iff (rst) locked_q |-> |(request & owner_q));
`endif

endmodule

// File: tb/tb_br_arb_rr_burst.sv
module tb_br_arb_rr_burst;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // N=3, Max=4
    logic [2:0] req3, last3, gnt3, bc3;
    logic       rdy3, lk3, de3;
    // N=2, Max=4
    logic [1:0] req2, last2, gnt2;
    logic [2:0] bc2;
    logic       rdy2, lk2, de2;
    // N=3, Max=1
    logic [2:0] reqm, lastm, gntm;
    logic [0:0] bcm;
    logic       rdym, lkm, dem;

    int n_vec = 0;
    int n_err = 0;

    br_arb_rr_burst #(.NumRequesters(3), .MaxBurstLength(4)) u_n3 (
        .clk(clk), .rst(rst), .request(req3), .request_last(last3), .ready(rdy3),
        .grant(gnt3), .locked(lk3), .beat_count(bc3), .drop_error(de3)
    );
    br_arb_rr_burst #(.NumRequesters(2), .MaxBurstLength(4)) u_n2 (
        .clk(clk), .rst(rst), .request(req2), .request_last(last2), .ready(rdy2),
        .grant(gnt2), .locked(lk2), .beat_count(bc2), .drop_error(de2)
    );
    br_arb_rr_burst #(.NumRequesters(3), .MaxBurstLength(1)) u_m1 (
        .clk(clk), .rst(rst), .request(reqm), .request_last(lastm), .ready(rdym),
        .grant(gntm), .locked(lkm), .beat_count(bcm), .drop_error(dem)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task clear_inputs();
        req3 = '0; last3 = '0; rdy3 = 1'b0;
        req2 = '0; last2 = '0; rdy2 = 1'b0;
        reqm = '0; lastm = '0; rdym = 1'b0;
    endtask

    // Called at a negedge; holds reset across one posedge, returns at the next negedge.
    task reset_all();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Plain rotation, N=3, every beat is a single-beat packet.
    logic [2:0] s1_gnt [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    // N=2 Max=4: req0 6-beat packet competing with req1 single beats.
    logic [1:0] s2_req  [8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10};
    logic [1:0] s2_last [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
    logic [1:0] s2_gnt  [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    logic       s2_lk   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] s2_bc   [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd1, 3'd0};

    // N=2: 3-beat packet with ready stalls.
    logic [1:0] s3_req  [6] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10};
    logic [1:0] s3_last [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    logic       s3_rdy  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] s3_gnt  [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    logic       s3_lk   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] s3_bc   [6] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd0};

    // Max=1: rotation every beat, never locked.
    logic [2:0] s4_gnt [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

    // N=3: req0 single beat, then req1 locks; reset lands at its beat 2.
    logic [2:0] s5_gnt [4] = '{3'b001, 3'b010, 3'b010, 3'b010};
    logic       s5_lk  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] s5_bc  [4] = '{3'd0, 3'd0, 3'd1, 3'd2};

    initial begin
        rst = 1'b1;
        clear_inputs();
        #1;
        check("rst_locked", 32'(lk3), 32'd0);
        check("rst_beat_count", 32'(bc3), 32'd0);
        check("rst_drop_error", 32'(de3), 32'd0);
        check("rst_grant_idle", 32'(gnt3), 32'd0);
        req3 = 3'b111; last3 = 3'b111; rdy3 = 1'b1;
        #1;
        check("rst_grant_comb", 32'(gnt3), 32'b001);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("s1_grant[%0d]", i), 32'(gnt3), 32'(s1_gnt[i]));
            check($sformatf("s1_locked[%0d]", i), 32'(lk3), 32'd0);
            @(negedge clk);
        end

        reset_all();
        rdy2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req2 = s2_req[i]; last2 = s2_last[i];
            #1;
            check($sformatf("s2_grant[%0d]", i), 32'(gnt2), 32'(s2_gnt[i]));
            check($sformatf("s2_locked[%0d]", i), 32'(lk2), 32'(s2_lk[i]));
            check($sformatf("s2_beat_count[%0d]", i), 32'(bc2), 32'(s2_bc[i]));
            @(negedge clk);
        end

        reset_all();
        for (int i = 0; i < 6; i++) begin
            req2 = s3_req[i]; last2 = s3_last[i]; rdy2 = s3_rdy[i];
            #1;
            check($sformatf("s3_grant[%0d]", i), 32'(gnt2), 32'(s3_gnt[i]));
            check($sformatf("s3_locked[%0d]", i), 32'(lk2), 32'(s3_lk[i]));
            check($sformatf("s3_beat_count[%0d]", i), 32'(bc2), 32'(s3_bc[i]));
            @(negedge clk);
        end

        reset_all();
        reqm = 3'b111; lastm = 3'b000; rdym = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("s4_grant[%0d]", i), 32'(gntm), 32'(s4_gnt[i]));
            check($sformatf("s4_locked[%0d]", i), 32'(lkm), 32'd0);
            check($sformatf("s4_beat_count[%0d]", i), 32'(bcm), 32'd0);
            @(negedge clk);
        end

        reset_all();
        req3 = 3'b111; last3 = 3'b001; rdy3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("s5_grant[%0d]", i), 32'(gnt3), 32'(s5_gnt[i]));
            check($sformatf("s5_locked[%0d]", i), 32'(lk3), 32'(s5_lk[i]));
            check($sformatf("s5_beat_count[%0d]", i), 32'(bc3), 32'(s5_bc[i]));
            if (i < 3) @(negedge clk);
        end
        // Mid-cycle reset with requests still held.
        #1;
        rst = 1'b1;
        #1;
        check("s5_async_locked", 32'(lk3), 32'd0);
        check("s5_async_beat_count", 32'(bc3), 32'd0);
        check("s5_async_grant", 32'(gnt3), 32'b001);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("s5_post_rst_grant", 32'(gnt3), 32'b001);
        check("s5_post_rst_locked", 32'(lk3), 32'd0);
        @(negedge clk);

`ifdef BR_ARB_RR_BURST_DROP_RELEASE_EN
        reset_all();
        req3 = 3'b111; last3 = 3'b000; rdy3 = 1'b1;
        #1;
        check("s6_grant_first", 32'(gnt3), 32'b001);
        check("s6_drop_idle", 32'(de3), 32'd0);
        @(negedge clk);
        req3 = 3'b110;
        #1;
        check("s6_drop_grant", 32'(gnt3), 32'b000);
        check("s6_drop_error", 32'(de3), 32'd1);
        check("s6_drop_locked", 32'(lk3), 32'd1);
        @(negedge clk);
        #1;
        check("s6_next_grant", 32'(gnt3), 32'b010);
        check("s6_drop_cleared", 32'(de3), 32'd0);
        check("s6_unlocked", 32'(lk3), 32'd0);
        @(negedge clk);
`endif

        reset_all();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
